chacha_keystream_ctrl: RTL and testbench

- Sequences keystream generation for the ChaCha20 datapath.
- Accepts a job of N 64-byte blocks, starts the block core once per block with an incrementing 32-bit block counter, and pulses the serialiser load.
- Tags the 16 serialised 32-bit words onto a keystream output with valid, byte-keep and last flags.
- Generation of block n+1 in the core overlaps serialisation of block n.

---
 rtl/chacha_keystream_ctrl.sv | 106 ++++++++++
 tb/tb_chacha_keystream_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_ctrl.sv
// chacha_keystream_ctrl: sequences ChaCha20 block generation and tags serialised words onto a keystream.
module chacha_keystream_ctrl #(
  parameter int WORDS_PER_BLOCK = 16,
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NBLK_W-1:0] req_nblocks,
  input  logic [31:0]       req_ctr,
  input  logic [6:0]        req_last_bytes,
  output logic              core_start,
  output logic [31:0]       core_ctr,
  input  logic              core_done,
  output logic              ser_load,
  input  logic [31:0]       ser_word,
  output logic              ks_valid,
  output logic [31:0]       ks_data,
  output logic [3:0]        ks_keep,
  output logic              ks_last,
  output logic              busy,
  output logic              done,
  output logic              err_ctr_wrap
);
  typedef enum logic [1:0] {IDLE, GEN, LOAD, STREAM} state_t;
  state_t state, state_nxt;
  logic [3:0] w;
  logic [NBLK_W-1:0] rem;
  logic [6:0] lb;
  logic fin, flag, accept, enter_load, more, wrap, last_w, last_c;
  logic [3:0] keep_c;
  assign accept = req_valid && req_ready;
  assign enter_load = (state_nxt == LOAD) && (state != LOAD);
  assign more = rem != NBLK_W'(1);
  assign wrap = more && (core_ctr == 32'hFFFF_FFFF);
  assign last_w = w == 4'(WORDS_PER_BLOCK - 1);
  assign last_c = fin && (w == 4'((lb - 7'd1) >> 2));
  always_comb begin
    for (int b = 0; b < 4; b++) keep_c[b] = !fin || ({1'b0, w, 2'(b)} < lb);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = (accept && req_nblocks != '0) ? GEN : IDLE;
      GEN:    state_nxt = (core_done || flag) ? LOAD : GEN;
      LOAD:   state_nxt = STREAM;
      STREAM: state_nxt = !last_w ? STREAM : fin ? IDLE : (flag || core_done) ? LOAD : GEN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    ser_load = state == LOAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0;
      rem <= '0;
      lb <= '0;
      fin <= 1'b0;
      flag <= 1'b0;
      core_start <= 1'b0;
      core_ctr <= '0;
      err_ctr_wrap <= 1'b0;
      done <= 1'b0;
      ks_valid <= 1'b0;
      ks_data <= '0;
      ks_keep <= '0;
      ks_last <= 1'b0;
    end else begin
      core_start <= 1'b0;
      w <= (state == STREAM) ? w + 4'd1 : 4'd0;
      flag <= (state == IDLE || state == LOAD) ? 1'b0 : (flag || core_done);
      done <= (accept && req_nblocks == '0) || (state == STREAM && last_w && fin);
      ks_valid <= (state == STREAM) && |keep_c;
      ks_keep <= (state == STREAM) ? keep_c : 4'd0;
      ks_last <= (state == STREAM) && last_c;
      ks_data <= (state == STREAM) ? ser_word : 32'd0;
      if (accept) begin
        rem <= req_nblocks;
        lb <= (req_last_bytes == 7'd0) ? 7'd64 : req_last_bytes;
        fin <= 1'b0;
        core_ctr <= req_ctr;
        core_start <= req_nblocks != '0;
        err_ctr_wrap <= 1'b0;
      end
      if (enter_load) begin
        fin <= !more || wrap;
        // A wrapped counter ends the job on this block, streamed in full
        if (wrap) begin
          err_ctr_wrap <= 1'b1;
          lb <= 7'd64;
        end else if (more) begin
          rem <= rem - NBLK_W'(1);
          core_ctr <= core_ctr + 32'd1;
          core_start <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// tb_chacha_keystream_ctrl: directed checks of job sequencing, keep/last tagging, wrap and reset.
module tb_chacha_keystream_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [15:0] req_nblocks = '0;
  logic [31:0] req_ctr = '0;
  logic [6:0] req_last_bytes = '0;
  logic core_start, core_done = 1'b0, ser_load;
  logic [31:0] core_ctr, ser_word = '0, ks_data;
  logic ks_valid, ks_last, busy, done, err_ctr_wrap;
  logic [3:0] ks_keep;
  int n_cmp = 0, n_bad = 0;
  int lat, cd_cnt, n_start, n_load, n_done, n_valid, n_last, last_pos, n_coinc, cyc, load_cyc0, done_cyc;
  bit done_last;
  logic [31:0] sctr[$];
  logic [3:0] kq[$];

  chacha_keystream_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_nblocks(req_nblocks), .req_ctr(req_ctr), .req_last_bytes(req_last_bytes),
    .core_start(core_start), .core_ctr(core_ctr), .core_done(core_done),
    .ser_load(ser_load), .ser_word(ser_word), .ks_valid(ks_valid), .ks_data(ks_data),
    .ks_keep(ks_keep), .ks_last(ks_last), .busy(busy), .done(done), .err_ctr_wrap(err_ctr_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sc(input int i);
    return (i < sctr.size()) ? sctr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] kk(input int i);
    return (i < kq.size()) ? 32'(kq[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_stats();
    n_start = 0; n_load = 0; n_done = 0; n_valid = 0; n_last = 0; last_pos = 0;
    n_coinc = 0; load_cyc0 = -1; done_cyc = -1; done_last = 0;
    sctr.delete(); kq.delete();
  endtask

  // one clock: sample #1 after the edge, model the core and log the keystream
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    core_done = 1'b0;
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) core_done = 1'b1;
    end
    if (core_start) begin
      sctr.push_back(core_ctr);
      n_start++;
      cd_cnt = lat;
    end
    if (ser_load) begin
      n_load++;
      if (load_cyc0 < 0) load_cyc0 = cyc;
      if (core_start) n_coinc++;
    end
    if (ks_valid) begin
      n_valid++;
      kq.push_back(ks_keep);
      check("ks_data", ks_data, ser_word);
      if (ks_last) begin
        n_last++;
        last_pos = n_valid;
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_last = ks_valid && ks_last;
    end
    ser_word = $urandom;
  endtask

  task automatic run_job(input int nb, input logic [31:0] ctr, input logic [6:0] lbi, input int l, input int budget);
    clear_stats();
    lat = l;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_nblocks = 16'(nb); req_ctr = ctr; req_last_bytes = lbi;
    tick();
    req_valid = 1'b0;
    while (n_done == 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (n_done == 0) check("job_timeout", 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    cyc = 0; cd_cnt = 0; lat = 1;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({core_start, ser_load, ks_valid, ks_last, done, err_ctr_wrap}), 32'd0);
    check("rst_ctr", core_ctr, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_job(1, 32'd7, 7'd64, 10, 200);
    check("t1_nstart", n_start, 1);
    check("t1_ctr", sc(0), 32'd7);
    check("t1_nload", n_load, 1);
    check("t1_nvalid", n_valid, 16);
    check("t1_keep15", kk(15), 32'hF);
    check("t1_keep0", kk(0), 32'hF);
    check("t1_lastpos", last_pos, 16);
    check("t1_nlast", n_last, 1);
    check("t1_ndone", n_done, 1);
    check("t1_done_last", 32'(done_last), 32'd1);

    run_job(3, 32'd0, 7'd64, 5, 300);
    check("t2_nstart", n_start, 3);
    check("t2_ctr0", sc(0), 32'd0);
    check("t2_ctr1", sc(1), 32'd1);
    check("t2_ctr2", sc(2), 32'd2);
    check("t2_coinc", n_coinc, 2);
    check("t2_nvalid", n_valid, 48);
    check("t2_span", done_cyc - load_cyc0, 51);
    check("t2_lastpos", last_pos, 48);
    check("t2_ndone", n_done, 1);

    run_job(2, 32'd100, 7'd6, 4, 300);
    check("t3_nstart", n_start, 2);
    check("t3_ctr1", sc(1), 32'd101);
    check("t3_nvalid", n_valid, 18);
    check("t3_keep_w0", kk(16), 32'hF);
    check("t3_keep_w1", kk(17), 32'h3);
    check("t3_lastpos", last_pos, 18);
    check("t3_nlast", n_last, 1);

    run_job(3, 32'hFFFF_FFFF, 7'd64, 3, 300);
    check("t4_nstart", n_start, 1);
    check("t4_nload", n_load, 1);
    check("t4_nvalid", n_valid, 16);
    check("t4_err", 32'(err_ctr_wrap), 32'd1);
    check("t4_lastpos", last_pos, 16);
    check("t4_ndone", n_done, 1);
    run_job(1, 32'd9, 7'd0, 3, 200);
    check("t4_err_clr", 32'(err_ctr_wrap), 32'd0);
    check("t4_lb0_nvalid", n_valid, 16);
    check("t4_lb0_keep", kk(15), 32'hF);
    check("t4_lb0_lastpos", last_pos, 16);

    run_job(0, 32'd5, 7'd64, 3, 20);
    check("t5_zero_done", n_done, 1);
    check("t5_zero_nstart", n_start, 0);
    check("t5_zero_nvalid", n_valid, 0);

    // request held high through a busy job is only taken once IDLE returns
    clear_stats();
    lat = 4;
    req_valid = 1'b1; req_nblocks = 16'd1; req_ctr = 32'd50; req_last_bytes = 7'd64;
    tick();
    req_ctr = 32'd60;
    for (int i = 0; i < 200 && n_done == 0; i++) begin
      tick();
      if (n_valid == 8 && ks_valid) check("t5_busy_ready", 32'(req_ready), 32'd0);
    end
    check("t5_hold_nstart", n_start, 1);
    tick();
    req_valid = 1'b0;
    check("t5_hold_nstart2", n_start, 2);
    check("t5_hold_ctr", sc(1), 32'd60);
    for (int i = 0; i < 200 && n_done < 2; i++) tick();
    check("t5_hold_ndone", n_done, 2);
    repeat (3) tick();

    clear_stats();
    lat = 4;
    req_valid = 1'b1; req_nblocks = 16'd2; req_ctr = 32'd20; req_last_bytes = 7'd64;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 200 && n_valid < 8; i++) tick();
    check("t6_reached_w8", n_valid, 8);
    #2 rst = 1'b1;
    #1;
    check("t6_ready", 32'(req_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_outs", 32'({core_start, ser_load, ks_valid, ks_last, done, err_ctr_wrap}), 32'd0);
    check("t6_data", ks_data, 32'd0);
    check("t6_ctr", core_ctr, 32'd0);
    cd_cnt = 0;
    core_done = 1'b0;
    @(posedge clk);
    #1;
    check("t6_hold_valid", 32'(ks_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    run_job(1, 32'd33, 7'd64, 4, 200);
    check("t6_nstart", n_start, 1);
    check("t6_ctr", sc(0), 32'd33);
    check("t6_nvalid", n_valid, 16);
    check("t6_ndone", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
